// File: rtl/mem_test_engine.sv
// Built-in memory test: writes SEED+i across a word region, reads it back,
// and reports the number of mismatching words and the first failing address.
module mem_test_engine #(
    parameter int          ADDR_W = 13,
    parameter logic [31:0] SEED   = 32'h1234_5678
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W:0]   num_words,
    output logic [ADDR_W-1:0] mem_address,
    output logic [3:0]        mem_byteenable,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [31:0]       mem_writedata,
    output logic              mem_clken,
    input  logic [31:0]       mem_readdata,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ADDR_W:0]   error_count,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic [2:0]        dbg_state
);

    typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_DRAIN, S_DONE} state_t;

    localparam logic [ADDR_W:0] MAX_WORDS = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] ONE       = {{ADDR_W{1'b0}}, 1'b1};

    state_t            state_q, state_d;
    logic [ADDR_W:0]   n_q, n_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W:0]   idx_q, idx_d;
    logic              rd_valid_q, rd_valid_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [31:0]       rd_exp_q, rd_exp_d;
    logic [ADDR_W:0]   err_q, err_d;
    logic [ADDR_W-1:0] first_q, first_d;
    logic              pass_q, pass_d;
    logic              clken_q;

    logic              last;
    logic [ADDR_W-1:0] cur_addr;
    logic [31:0]       cur_data;

    assign last     = (idx_q == n_q - ONE);
    assign cur_addr = base_q + idx_q[ADDR_W-1:0];
    assign cur_data = SEED + 32'(idx_q);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            n_q        <= '0;
            base_q     <= '0;
            idx_q      <= '0;
            rd_valid_q <= 1'b0;
            rd_addr_q  <= '0;
            rd_exp_q   <= '0;
            err_q      <= '0;
            first_q    <= '0;
            pass_q     <= 1'b0;
            clken_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            n_q        <= n_d;
            base_q     <= base_d;
            idx_q      <= idx_d;
            rd_valid_q <= rd_valid_d;
            rd_addr_q  <= rd_addr_d;
            rd_exp_q   <= rd_exp_d;
            err_q      <= err_d;
            first_q    <= first_d;
            pass_q     <= pass_d;
            clken_q    <= 1'b1;
        end
    end

    // start is a request taken only in IDLE; busy high means it is not being listened to.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = (num_words == '0) ? S_DONE : S_WRITE;
            S_WRITE: if (last) state_d = S_READ;
            S_READ:  if (last) state_d = S_DRAIN;
            S_DRAIN: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        n_d        = n_q;
        base_d     = base_q;
        idx_d      = idx_q;
        err_d      = err_q;
        first_d    = first_q;
        pass_d     = pass_q;
        rd_valid_d = (state_q == S_READ);
        rd_addr_d  = cur_addr;
        rd_exp_d   = cur_data;

        // Read data returns one cycle after its address; compare it against the delayed expectation.
        if (rd_valid_q && (mem_readdata != rd_exp_q)) begin
            err_d = err_q + ONE;
            if (err_q == '0) first_d = rd_addr_q;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    n_d     = (num_words > MAX_WORDS) ? MAX_WORDS : num_words;
                    base_d  = start_addr;
                    idx_d   = '0;
                    err_d   = '0;
                    first_d = '0;
                    pass_d  = (num_words == '0);
                end
            end
            S_WRITE, S_READ: idx_d = last ? '0 : idx_q + ONE;
            S_DRAIN: pass_d = (err_d == '0);
            default: ;
        endcase
    end

    always_comb begin
        mem_chipselect = 1'b0;
        mem_write      = 1'b0;
        mem_address    = '0;
        mem_writedata  = '0;
        busy           = (state_q != S_IDLE);
        done           = (state_q == S_DONE);
        case (state_q)
            S_WRITE: begin
                mem_chipselect = 1'b1;
                mem_write      = 1'b1;
                mem_address    = cur_addr;
                mem_writedata  = cur_data;
            end
            S_READ: begin
                mem_chipselect = 1'b1;
                mem_address    = cur_addr;
            end
            default: ;
        endcase
    end

    assign mem_byteenable = 4'hF;
    assign mem_clken      = clken_q;
    assign pass           = pass_q;
    assign error_count    = err_q;
    assign first_err_addr = first_q;
    assign dbg_state      = state_q;

endmodule

// File: tb/tb_mem_test_engine.sv
// Bench for mem_test_engine: bus-level memory with optional bit-0 corruption,
// a run-level reference model, a per-cycle compare process, and directed plus random runs.
module tb_mem_test_engine;

    localparam int          AW    = 13;
    localparam int          DEPTH = 1 << AW;
    localparam logic [31:0] SEED  = 32'h1234_5678;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] start_addr = '0;
    logic [AW:0]   num_words = '0;
    logic [AW-1:0] mem_address;
    logic [3:0]    mem_byteenable;
    logic          mem_chipselect;
    logic          mem_write;
    logic [31:0]   mem_writedata;
    logic          mem_clken;
    logic [31:0]   mem_readdata;
    logic          busy;
    logic          done;
    logic          pass;
    logic [AW:0]   error_count;
    logic [AW-1:0] first_err_addr;
    logic [2:0]    dbg_state;

    int checks = 0;
    int errors = 0;

    mem_test_engine #(.ADDR_W(AW), .SEED(SEED)) dut (
        .clk(clk), .reset(reset), .start(start), .start_addr(start_addr),
        .num_words(num_words), .mem_address(mem_address),
        .mem_byteenable(mem_byteenable), .mem_chipselect(mem_chipselect),
        .mem_write(mem_write), .mem_writedata(mem_writedata),
        .mem_clken(mem_clken), .mem_readdata(mem_readdata), .busy(busy),
        .done(done), .pass(pass), .error_count(error_count),
        .first_err_addr(first_err_addr), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory slave: registered read data, optional bit-0 flip on one address.
    logic [31:0] mem [DEPTH];
    logic [31:0] rdata_q = '0;
    bit          corrupt_en = 1'b0;
    int          corrupt_addr = 0;
    always @(posedge clk) begin
        if (mem_chipselect) begin
            if (mem_write) mem[mem_address] <= mem_writedata;
            else rdata_q <= mem[mem_address] ^ ((corrupt_en && int'(mem_address) == corrupt_addr) ? 32'd1 : 32'd0);
        end
    end
    assign mem_readdata = rdata_q;

    int done_cnt = 0;
    int cs_cnt = 0;
    always @(posedge clk) begin
        if (done) done_cnt++;
        if (mem_chipselect) cs_cnt++;
    end

    // Reference model: one run = N writes, N reads, one drain, one done cycle.
    bit m_active = 0;
    bit m_clk_seen = 0;
    int m_cyc, m_sa, m_n, m_lat;
    int e_err, e_first;
    bit m_pass = 0;
    int m_err = 0, m_first = 0;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_active = 0; m_clk_seen = 0; m_pass = 0; m_err = 0; m_first = 0;
        end else begin
            m_clk_seen = 1;
            if (m_active) begin
                if (m_cyc == m_lat) begin
                    m_active = 0;
                    m_pass = (e_err == 0);
                    m_err = e_err;
                    m_first = e_first;
                end else m_cyc++;
            end else if (start) begin
                m_sa = int'(start_addr);
                m_n = (int'(num_words) > DEPTH) ? DEPTH : int'(num_words);
                m_lat = (m_n == 0) ? 1 : 2 * m_n + 2;
                m_active = 1;
                m_cyc = 1;
                e_err = 0;
                e_first = 0;
                for (int i = 0; i < m_n; i++) begin
                    if (corrupt_en && ((m_sa + i) % DEPTH) == corrupt_addr) begin
                        if (e_err == 0) e_first = (m_sa + i) % DEPTH;
                        e_err++;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin : cmp
        int c, i;
        bit exp_cs, exp_wr;
        if (reset) begin
            chk("rst_address", 32'(mem_address), 32'd0);
            chk("rst_cs", 32'(mem_chipselect), 32'd0);
            chk("rst_write", 32'(mem_write), 32'd0);
            chk("rst_wdata", mem_writedata, 32'd0);
            chk("rst_be", 32'(mem_byteenable), 32'hF);
            chk("rst_clken", 32'(mem_clken), 32'd0);
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_done", 32'(done), 32'd0);
            chk("rst_pass", 32'(pass), 32'd0);
            chk("rst_errcnt", 32'(error_count), 32'd0);
            chk("rst_first", 32'(first_err_addr), 32'd0);
        end else begin
            chk("byteenable", 32'(mem_byteenable), 32'hF);
            if (m_clk_seen) chk("clken", 32'(mem_clken), 32'd1);
            if (m_active) begin
                c = m_cyc;
                exp_cs = (c <= 2 * m_n);
                exp_wr = (c <= m_n);
                i = exp_wr ? c - 1 : c - m_n - 1;
                chk("busy", 32'(busy), 32'd1);
                chk("cs", 32'(mem_chipselect), 32'(exp_cs));
                chk("write", 32'(mem_write), 32'(exp_wr));
                if (exp_cs) chk("address", 32'(mem_address), 32'((m_sa + i) % DEPTH));
                if (exp_wr) chk("wdata", mem_writedata, SEED + 32'(i));
                chk("done", 32'(done), 32'(c == m_lat));
                if (c == m_lat) begin
                    chk("done_pass", 32'(pass), 32'(e_err == 0));
                    chk("done_errcnt", 32'(error_count), 32'(e_err));
                    chk("done_first", 32'(first_err_addr), 32'(e_first));
                end
            end else begin
                chk("idle_busy", 32'(busy), 32'd0);
                chk("idle_done", 32'(done), 32'd0);
                chk("idle_cs", 32'(mem_chipselect), 32'd0);
                chk("idle_write", 32'(mem_write), 32'd0);
                chk("idle_pass", 32'(pass), 32'(m_pass));
                chk("idle_errcnt", 32'(error_count), 32'(m_err));
                chk("idle_first", 32'(first_err_addr), 32'(m_first));
            end
        end
    end

    task automatic wait_done(output int dcyc);
        dcyc = -1;
        for (int c = 1; c <= 20000; c++) begin
            @(negedge clk);
            if (done) begin
                dcyc = c;
                break;
            end
        end
        if (dcyc < 0) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done expected done within 20000 cycles");
        end
    endtask

    task automatic run(input int sa, input int nw, input bit cen, input int caddr, output int dcyc);
        @(negedge clk);
        start_addr = AW'(sa);
        num_words = (AW + 1)'(nw);
        corrupt_en = cen;
        corrupt_addr = caddr;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(dcyc);
    endtask

    initial begin : main
        int d, d1, d2, snap, sa, n, caddr;
        bit cen;
        repeat (3) @(posedge clk);
        $display("state after reset: %0d", dbg_state);
        #1 reset = 1'b0;

        run(0, 4, 0, 0, d);
        chk("ideal_latency", 32'(d), 32'd10);
        chk("ideal_mem0", mem[0], 32'h1234_5678);
        chk("ideal_mem3", mem[3], 32'h1234_567B);
        chk("ideal_pass", 32'(pass), 32'd1);

        run(0, 4, 1, 2, d);
        chk("corrupt_pass", 32'(pass), 32'd0);
        chk("corrupt_errcnt", 32'(error_count), 32'd1);
        chk("corrupt_first", 32'(first_err_addr), 32'd2);

        snap = cs_cnt;
        run(5, 0, 0, 0, d);
        chk("zero_latency", 32'(d), 32'd1);
        chk("zero_pass", 32'(pass), 32'd1);
        chk("zero_errcnt", 32'(error_count), 32'd0);
        @(negedge clk);
        chk("zero_no_cs", 32'(cs_cnt - snap), 32'd0);

        run(8190, 4, 0, 0, d);
        chk("wrap_mem8190", mem[8190], 32'h1234_5678);
        chk("wrap_mem8191", mem[8191], 32'h1234_5679);
        chk("wrap_mem0", mem[0], 32'h1234_567A);
        chk("wrap_mem1", mem[1], 32'h1234_567B);
        chk("wrap_pass", 32'(pass), 32'd1);

        // Abort a 16-word run in its read phase.
        @(negedge clk);
        start_addr = '0; num_words = 16; corrupt_en = 0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (20) @(negedge clk);
        chk("abort_in_read", 32'(mem_chipselect & ~mem_write), 32'd1);
        snap = done_cnt;
        @(posedge clk);
        #1 reset = 1'b1;
        #1;
        chk("abort_cs", 32'(mem_chipselect), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_address", 32'(mem_address), 32'd0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        start_addr = 40; num_words = 2; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        chk("abort_no_done", 32'(done_cnt - snap), 32'd0);
        wait_done(d);
        chk("post_abort_latency", 32'(d), 32'd6);
        chk("post_abort_pass", 32'(pass), 32'd1);

        // start held high across a whole 8-word run.
        @(negedge clk);
        start_addr = 100; num_words = 8; start = 1'b1;
        @(posedge clk);
        d1 = -1; d2 = -1;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (c == 19) chk("held_idle_gap", 32'(busy), 32'd0);
            if (c == 20) start = 1'b0;
            if (done) begin
                if (d1 < 0) d1 = c;
                else begin
                    d2 = c;
                    break;
                end
            end
        end
        chk("held_first_done", 32'(d1), 32'd18);
        chk("held_second_done", 32'(d2), 32'd37);

        run(5, 9000, 1, 4, d);
        chk("clamp_latency", 32'(d), 32'd16386);
        chk("clamp_errcnt", 32'(error_count), 32'd1);
        chk("clamp_first", 32'(first_err_addr), 32'd4);

        for (int r = 0; r < 14; r++) begin
            sa = (r % 3 == 0) ? DEPTH - int'($urandom_range(1, 8)) : int'($urandom_range(0, DEPTH - 1));
            n = (r % 5 == 4) ? 0 : int'($urandom_range(1, 40));
            cen = 1'($urandom_range(0, 1));
            caddr = (cen && n > 0) ? (sa + int'($urandom_range(0, n - 1))) % DEPTH : 0;
            run(sa, n, cen, caddr, d);
            chk("rand_latency", 32'(d), 32'((n == 0) ? 1 : 2 * n + 2));
            chk("rand_pass", 32'(pass), 32'(!(cen && n > 0)));
        end

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
